// File: rtl/kernel_window_gen_if.sv
// Column-in / window-out handshake bundle for kernel_window_gen.
// master drives columns and window back-pressure; slave is the window generator.
interface kernel_window_gen_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_WIDTH = 3,
    parameter int IMG_WIDTH    = 854
);
    localparam int X_WIDTH = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [DATA_WIDTH*KERNEL_WIDTH-1:0]              col_data;
    logic                                            col_valid;
    logic                                            col_ready;
    logic                                            border_in;
    logic [DATA_WIDTH*KERNEL_WIDTH*KERNEL_WIDTH-1:0] win_data;
    logic                                            win_valid;
    logic                                            win_ready;
    logic [X_WIDTH-1:0]                              win_x;
    logic                                            line_last;

    modport master (
        output col_data, col_valid, border_in, win_ready,
        input  col_ready, win_data, win_valid, win_x, line_last
    );

    modport slave (
        input  col_data, col_valid, border_in, win_ready,
        output col_ready, win_data, win_valid, win_x, line_last
    );
endinterface

// File: rtl/kernel_window_gen.sv
// Shifts KERNEL_WIDTH-tall pixel columns into a KxK window and emits it over valid/ready.
// Optional ZERO_PAD_EN: emit windows from line column 0 with not-yet-received columns read as 0.
module kernel_window_gen #(
    parameter int DATA_WIDTH   = 8,
    parameter int KERNEL_WIDTH = 3,
    parameter int IMG_WIDTH    = 854
) (
    input  logic              clk,
    input  logic              rst,
    kernel_window_gen_if.slave bus
);
    localparam int K       = KERNEL_WIDTH;
    localparam int X_WIDTH = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int F_WIDTH = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [X_WIDTH-1:0] LAST_X    = X_WIDTH'(IMG_WIDTH - 1);
    localparam logic [F_WIDTH-1:0] FILL_LAST = F_WIDTH'(K - 2);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t                    state_reg, state_next;
    logic [F_WIDTH-1:0]        fill_cnt_reg, fill_cnt_next;
    logic [X_WIDTH-1:0]        col_cnt_reg;
    logic [X_WIDTH-1:0]        win_x_reg;
    logic                      win_valid_reg;
    logic                      line_last_reg;
    logic [K*DATA_WIDTH-1:0]   col_reg [K];

    logic col_ready_w;
    logic accept;
    logic emit;
    logic line_end;

    // Single output register: a new column is taken only when the window slot frees up.
    assign col_ready_w = !win_valid_reg || bus.win_ready;
    assign accept      = bus.col_valid && col_ready_w;
    assign line_end    = (col_cnt_reg == LAST_X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_FILL;
            fill_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        emit          = 1'b0;
        case (state_reg)
            S_FILL: begin
`ifdef ZERO_PAD_EN
                emit = !bus.border_in;
`endif
                if (accept) begin
                    if (fill_cnt_reg == FILL_LAST) begin
                        state_next    = S_RUN;
                        fill_cnt_next = '0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + 1'b1;
                    end
                end
            end
            S_RUN: begin
                emit = !bus.border_in;
                if (accept && line_end) begin
                    state_next    = S_FILL;
                    fill_cnt_next = '0;
                end
            end
            default: begin
                state_next    = S_FILL;
                fill_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_reg   <= '0;
            win_x_reg     <= '0;
            win_valid_reg <= 1'b0;
            line_last_reg <= 1'b0;
            for (int c = 0; c < K; c++) begin
                col_reg[c] <= '0;
            end
        end else if (accept) begin
            col_cnt_reg   <= line_end ? '0 : col_cnt_reg + 1'b1;
            win_x_reg     <= col_cnt_reg;
            win_valid_reg <= emit;
            line_last_reg <= emit && line_end;
            for (int c = 0; c < K - 1; c++) begin
`ifdef ZERO_PAD_EN
                // At line column 0 the older columns belong to the previous line: blank them.
                col_reg[c] <= (col_cnt_reg == '0) ? '0 : col_reg[c+1];
`else
                col_reg[c] <= col_reg[c+1];
`endif
            end
            col_reg[K-1] <= bus.col_data;
        end else if (bus.win_ready) begin
            win_valid_reg <= 1'b0;
            line_last_reg <= 1'b0;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < K; gi++) begin : g_col
            for (gj = 0; gj < K; gj++) begin : g_row
                assign bus.win_data[(gj*K+gi)*DATA_WIDTH +: DATA_WIDTH] =
                    col_reg[gi][gj*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    endgenerate

    assign bus.col_ready = col_ready_w;
    assign bus.win_valid = win_valid_reg;
    assign bus.win_x     = win_x_reg;
    assign bus.line_last = line_last_reg;
endmodule

// File: tb/tb_kernel_window_gen.sv
// Bench for kernel_window_gen (K=3, 8-pixel lines): cycle table, directed sequences and random traffic vs a line model.
module tb_kernel_window_gen;
    localparam int DW = 8;
    localparam int K  = 3;
    localparam int IW = 8;
`ifdef ZERO_PAD_EN
    localparam bit ZP  = 1'b1;
    localparam int WPL = 8;
    localparam int BWL = 6;
`else
    localparam bit ZP  = 1'b0;
    localparam int WPL = 6;
    localparam int BWL = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    kernel_window_gen_if #(.DATA_WIDTH(DW), .KERNEL_WIDTH(K), .IMG_WIDTH(IW)) bus ();
    kernel_window_gen #(.DATA_WIDTH(DW), .KERNEL_WIDTH(K), .IMG_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] coldata(int x);
        return {8'(x + 32), 8'(x + 16), 8'(x)};
    endfunction

    // Window expected for the fixed line pattern whose newest column is x.
    function automatic logic [71:0] pat_window(int x);
        logic [71:0] w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                int src = x - (K - 1) + c;
                w[(r*K+c)*DW +: DW] = (src < 0) ? 8'h00 : 8'(src + 16 * r);
            end
        end
        return w;
    endfunction

    // Reference model: the pixels of the current line by column index.
    logic [23:0] line_cols [IW];
    typedef struct {
        logic [71:0] d;
        int          x;
        bit          last;
    } win_t;
    win_t exp_q[$];
    int   seen_x[$];
    int   mx;
    int   win_cnt;

    function automatic logic [71:0] window_at(int x);
        logic [71:0] w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                int src = x - (K - 1) + c;
                w[(r*K+c)*DW +: DW] = (src < 0) ? 8'h00 : line_cols[src][r*DW +: DW];
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        seen_x.delete();
        mx      = 0;
        win_cnt = 0;
        for (int i = 0; i < IW; i++) line_cols[i] = '0;
    endtask

    task automatic cycle(bit cv, logic [23:0] cd, bit bord, bit wr);
        logic [71:0] hd;
        logic [2:0]  hx;
        bit          held;
        bus.col_valid = cv;
        bus.col_data  = cd;
        bus.border_in = bord;
        bus.win_ready = wr;
        #1;
        chk("col_ready", 128'(bus.col_ready), 128'(!bus.win_valid || wr));
        held = bus.win_valid && !wr;
        hd   = bus.win_data;
        hx   = bus.win_x;
        if (bus.win_valid && wr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_window: got win_x=%0d expected none", bus.win_x);
            end else begin
                win_t e = exp_q.pop_front();
                chk("win_data", 128'(bus.win_data), 128'(e.d));
                chk("win_x", 128'(bus.win_x), 128'(e.x));
                chk("line_last", 128'(bus.line_last), 128'(e.last));
            end
            seen_x.push_back(int'(bus.win_x));
            win_cnt++;
        end
        if (cv && bus.col_ready) begin
            line_cols[mx] = cd;
            if (!bord && (ZP || mx >= K - 1)) exp_q.push_back('{window_at(mx), mx, mx == IW - 1});
            mx = (mx + 1) % IW;
        end
        @(posedge clk);
        #1;
        if (held) begin
            chk("hold_valid", 128'(bus.win_valid), 128'(1));
            chk("hold_data", 128'(bus.win_data), 128'(hd));
            chk("hold_x", 128'(bus.win_x), 128'(hx));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) cycle(1'b0, 24'h0, 1'b0, 1'b1);
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.col_valid = 1'b0;
        bus.win_ready = 1'b0;
        bus.border_in = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_win_valid"}, 128'(bus.win_valid), 128'(0));
        chk({tag, "_win_data"}, 128'(bus.win_data), 128'(0));
        chk({tag, "_win_x"}, 128'(bus.win_x), 128'(0));
        chk({tag, "_line_last"}, 128'(bus.line_last), 128'(0));
    endtask

    typedef struct {
        bit cv;
        int cx;
        bit wr;
        bit e_cr;
        bit e_wv;
        int e_x;
        bit e_last;
    } vec_t;
    vec_t tbl[$];

    initial begin
        rst           = 1'b1;
        bus.col_valid = 1'b0;
        bus.col_data  = '0;
        bus.border_in = 1'b0;
        bus.win_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        chk("reset_col_ready", 128'(bus.col_ready), 128'(1));
        rst = 1'b0;

        // Cycle table: line fill with 5 cycles of back-pressure after the first window.
`ifdef ZERO_PAD_EN
        for (int x = 0; x < IW; x++) tbl.push_back('{1, x, 1, 1, 1, x, x == IW - 1});
`else
        tbl.push_back('{1, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 2, 1, 1, 1, 2, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{1, 3, 0, 0, 1, 2, 0});
        for (int x = 3; x < IW; x++) tbl.push_back('{1, x, 1, 1, 1, x, x == IW - 1});
`endif
        tbl.push_back('{0, 0, 1, 1, 0, 0, 0});
        for (int i = 0; i < tbl.size(); i++) begin
            bus.col_valid = tbl[i].cv;
            bus.col_data  = coldata(tbl[i].cx);
            bus.border_in = 1'b0;
            bus.win_ready = tbl[i].wr;
            @(posedge clk);
            #1;
            chk("tbl_col_ready", 128'(bus.col_ready), 128'(tbl[i].e_cr));
            chk("tbl_win_valid", 128'(bus.win_valid), 128'(tbl[i].e_wv));
            if (tbl[i].e_wv) begin
                chk("tbl_win_x", 128'(bus.win_x), 128'(tbl[i].e_x));
                chk("tbl_line_last", 128'(bus.line_last), 128'(tbl[i].e_last));
                chk("tbl_win_data", 128'(bus.win_data), 128'(pat_window(tbl[i].e_x)));
            end
        end

        // Border columns 4 and 5 suppress their windows.
        do_reset();
        for (int x = 0; x < IW; x++) cycle(1'b1, coldata(x), (x == 4) || (x == 5), 1'b1);
        drain();
        chk("border_count", 128'(win_cnt), 128'(BWL));

        // Two lines back-to-back.
        do_reset();
        for (int l = 0; l < 2; l++)
            for (int x = 0; x < IW; x++) cycle(1'b1, coldata(x + 64 * l), 1'b0, 1'b1);
        drain();
        chk("wrap_count", 128'(win_cnt), 128'(2 * WPL));

        // Reset in the middle of a line.
        do_reset();
        for (int x = 0; x < 5; x++) cycle(1'b1, coldata(x), 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk_zero("midrst_async");
        model_reset();
        @(posedge clk);
        #1;
        chk_zero("midrst_held");
        rst = 1'b0;
        for (int x = 0; x < IW; x++) cycle(1'b1, coldata(x + 100), 1'b0, 1'b1);
        drain();
        chk("midrst_count", 128'(win_cnt), 128'(WPL));
        if (seen_x.size() > 0) chk("midrst_first_x", 128'(seen_x[0]), 128'(ZP ? 0 : 2));
        else chk("midrst_first_x", 128'(0), 128'(1));

        // Random traffic against the line model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, 24'($urandom), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
